// File: rtl/ang_pkg.sv
// Shared types and constants for the candidate angle sorter.
// Entries are {theta,phi}; scores stay internal to the slot chain.
package ang_pkg;

  localparam int N_CAND  = 10;
  localparam int ANGLE_W = 12;
  localparam int SCORE_W = 16;
  localparam int ENTRY_W = 2 * ANGLE_W;
  localparam int CNT_W   = 4;

  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [SCORE_W-1:0] score_t;

  typedef struct packed {
    logic   valid;
    score_t score;
    entry_t entry;
  } slot_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

endpackage

// File: rtl/cand_slot.sv
// One entry of the sorted table: holds, loads the new
// candidate, or takes the entry shifted down from the slot above.
module cand_slot
  import ang_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_clr,
  input  logic  i_ins,
  input  logic  i_prev_ge,
  input  slot_t i_prev,
  input  slot_t i_new,
  output slot_t o_slot,
  output logic  o_ge
);

  slot_t r_slot;

  // Equal scores stay ahead, so later arrivals land behind them.
  assign o_ge   = r_slot.valid && (r_slot.score >= i_new.score);
  assign o_slot = r_slot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
    end else if (i_ins && !o_ge) begin
      r_slot <= i_prev_ge ? i_new : i_prev;
    end
  end

endmodule

// File: rtl/candidate_angle_sorter.sv
// Keeps the ten best-scoring {theta,phi} candidates of a search,
// sorted by descending score, one insertion per clock.
module candidate_angle_sorter
  import ang_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       score_rdy,
  input  logic [ANGLE_W-1:0]         theta,
  input  logic [ANGLE_W-1:0]         phi,
  input  logic [SCORE_W-1:0]         score,
  input  logic                       if_last_angle,
  output logic [N_CAND*ENTRY_W-1:0]  candidate_angle_buffer,
  output logic [CNT_W-1:0]           num_valid,
  output logic                       sorted_rdy
);

  state_t           r_state;
  state_t           w_next;
  logic             r_start;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_clr;
  logic             w_ins;
  slot_t            w_new;
  slot_t            w_slot [N_CAND];
  logic             w_ge   [N_CAND];

  assign w_rise = start && !r_start;

  assign w_new.valid = 1'b1;
  assign w_new.score = score;
  assign w_new.entry = {theta, phi};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= start;
    end
  end

  // A start edge wins over any score arriving in the same cycle.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_ins  = 1'b0;
    if (w_rise) begin
      w_clr  = 1'b1;
      w_next = S_COLLECT;
    end else begin
      unique case (r_state)
        S_COLLECT: begin
          if (score_rdy) begin
            w_ins = 1'b1;
            if (if_last_angle) w_next = S_DONE;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_ins && (r_cnt != CNT_W'(N_CAND))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CAND; i++) begin : g_slot
    slot_t w_prev;
    logic  w_prev_ge;
    if (i == 0) begin : g_head
      assign w_prev    = '0;
      assign w_prev_ge = 1'b1;
    end else begin : g_link
      assign w_prev    = w_slot[i-1];
      assign w_prev_ge = w_ge[i-1];
    end
    cand_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_ins     (w_ins),
      .i_prev_ge (w_prev_ge),
      .i_prev    (w_prev),
      .i_new     (w_new),
      .o_slot    (w_slot[i]),
      .o_ge      (w_ge[i])
    );
  end

  always_comb begin
    candidate_angle_buffer = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (w_slot[i].valid)
        candidate_angle_buffer[i*ENTRY_W +: ENTRY_W] = w_slot[i].entry;
    end
  end

  assign num_valid  = r_cnt;
  assign sorted_rdy = (r_state == S_DONE);

endmodule

// File: tb/tb_candidate_angle_sorter.sv
// Directed table-driven bench for candidate_angle_sorter.
module tb_candidate_angle_sorter;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        last;
    logic [11:0] th;
    logic [11:0] ph;
    logic [15:0] sc;
    logic [3:0]  nv;
    logic        sr;
    logic [23:0] e0;
    logic [23:0] e9;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         score_rdy;
  logic [11:0]  theta;
  logic [11:0]  phi;
  logic [15:0]  score;
  logic         if_last_angle;
  logic [239:0] buf_o;
  logic [3:0]   num_valid;
  logic         sorted_rdy;

  vec_t tbl [80];
  int   n = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  candidate_angle_sorter dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .score_rdy              (score_rdy),
    .theta                  (theta),
    .phi                    (phi),
    .score                  (score),
    .if_last_angle          (if_last_angle),
    .candidate_angle_buffer (buf_o),
    .num_valid              (num_valid),
    .sorted_rdy             (sorted_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input int t, input int p);
    logic [11:0] tt;
    logic [11:0] pp;
    tt = 12'(t);
    pp = 12'(p);
    return {tt, pp};
  endfunction

  task automatic chk(input string nm, input logic [239:0] act,
                     input logic [239:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic rdy, input logic last,
                     input int th, input int ph, input int sc,
                     input int nv, input logic sr,
                     input logic [23:0] e0, input logic [23:0] e9);
    tbl[n].st   = st;
    tbl[n].rdy  = rdy;
    tbl[n].last = last;
    tbl[n].th   = 12'(th);
    tbl[n].ph   = 12'(ph);
    tbl[n].sc   = 16'(sc);
    tbl[n].nv   = 4'(nv);
    tbl[n].sr   = sr;
    tbl[n].e0   = e0;
    tbl[n].e9   = e9;
    n++;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      start         = tbl[i].st;
      score_rdy     = tbl[i].rdy;
      if_last_angle = tbl[i].last;
      theta         = tbl[i].th;
      phi           = tbl[i].ph;
      score         = tbl[i].sc;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d num_valid", i), 240'(num_valid), 240'(tbl[i].nv));
      chk($sformatf("row%0d sorted_rdy", i), 240'(sorted_rdy), 240'(tbl[i].sr));
      chk($sformatf("row%0d entry0", i), 240'(buf_o[23:0]), 240'(tbl[i].e0));
      chk($sformatf("row%0d entry9", i), 240'(buf_o[239:216]), 240'(tbl[i].e9));
    end
    start     = 1'b0;
    score_rdy = 1'b0;
  endtask

  initial begin
    logic [239:0] exp_buf;
    int s_a;
    int s_b;
    int s_c;
    int s_d;
    int s_e;

    // A: three scores, last on the third, then a score in DONE
    add(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    add(0, 1, 0, 1, 10, 5, 1, 0, mk(1, 10), '0);
    add(0, 1, 0, 2, 20, 9, 2, 0, mk(2, 20), '0);
    add(0, 1, 1, 3, 30, 1, 3, 1, mk(2, 20), '0);
    s_a = n;
    add(0, 1, 0, 50, 50, 100, 3, 1, mk(2, 20), '0);
    add(0, 0, 0, 0, 0, 0, 3, 1, mk(2, 20), '0);
    s_b = n;
    // B: scores 1..12, theta=score
    add(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    for (int k = 1; k <= 12; k++)
      add(0, 1, 0, k, 0, k, (k < 10) ? k : 10, 0, mk(k, 0),
          (k < 10) ? 24'd0 : mk(k - 9, 0));
    s_c = n;
    // C: full table, tie with entry9 then just above it
    add(0, 1, 0, 99, 0, 3, 10, 0, mk(12, 0), mk(3, 0));
    add(0, 1, 0, 98, 0, 4, 10, 0, mk(12, 0), mk(98, 0));
    // D: restart with a dropped same-cycle score, then a tie
    add(0, 0, 0, 0, 0, 0, 10, 0, mk(12, 0), mk(98, 0));
    add(1, 1, 0, 50, 50, 50, 0, 0, '0, '0);
    add(0, 1, 0, 1, 0, 7, 1, 0, mk(1, 0), '0);
    add(0, 1, 0, 2, 0, 7, 2, 0, mk(1, 0), '0);
    s_d = n;
    add(0, 0, 1, 9, 9, 9, 2, 0, mk(1, 0), '0);
    add(0, 1, 0, 3, 0, 3, 3, 0, mk(1, 0), '0);
    add(0, 1, 0, 4, 0, 8, 4, 0, mk(4, 0), '0);
    // E: restart after 4 insertions, one last score, DONE is frozen
    add(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    add(0, 1, 1, 7, 7, 5, 1, 1, mk(7, 7), '0);
    add(0, 1, 0, 1, 1, 900, 1, 1, mk(7, 7), '0);
    add(0, 1, 1, 2, 2, 901, 1, 1, mk(7, 7), '0);
    s_e = n;

    rst = 1'b0; start = 1'b0; score_rdy = 1'b0; if_last_angle = 1'b0;
    theta = '0; phi = '0; score = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset sorted_rdy", 240'(sorted_rdy), 240'(0));
    chk("reset num_valid", 240'(num_valid), 240'(0));
    chk("reset buffer", buf_o, '0);

    run(0, s_a);
    exp_buf = '0;
    exp_buf[23:0]  = mk(2, 20);
    exp_buf[47:24] = mk(1, 10);
    exp_buf[71:48] = mk(3, 30);
    chk("three-score buffer", buf_o, exp_buf);
    run(s_a, s_b);
    chk("done-hold buffer", buf_o, exp_buf);

    run(s_b, s_c);
    exp_buf = '0;
    for (int i = 0; i < 10; i++) exp_buf[i*24 +: 24] = mk(12 - i, 0);
    chk("twelve-score buffer", buf_o, exp_buf);

    run(s_c, s_d);
    exp_buf = '0;
    exp_buf[23:0]  = mk(1, 0);
    exp_buf[47:24] = mk(2, 0);
    chk("tie buffer", buf_o, exp_buf);

    run(s_d, s_e);
    exp_buf = '0;
    exp_buf[23:0] = mk(7, 7);
    chk("restart buffer", buf_o, exp_buf);

    // Reset overrides a start edge and a score in the same cycle
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b1; score_rdy = 1'b1; score = 16'd77;
    theta = 12'd5; phi = 12'd5;
    @(posedge clk);
    #1;
    chk("reset-override sorted_rdy", 240'(sorted_rdy), 240'(0));
    chk("reset-override num_valid", 240'(num_valid), 240'(0));
    chk("reset-override buffer", buf_o, '0);
    rst = 1'b1; start = 1'b0; score_rdy = 1'b0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
